// File: rtl/ram_if.sv
// ram_if: bundles the write and read port signals of the ram block.
// The master side drives enables, addresses and write data; the slave
// side (the ram itself) returns registered read data.
interface ram_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  wr_enb;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_enb;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        output wr_enb,
        output wr_addr,
        output wr_data,
        output rd_enb,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_enb,
        input  wr_addr,
        input  wr_data,
        input  rd_enb,
        input  rd_addr,
        output rd_data
    );
endinterface

// File: rtl/ram.sv
// ram: 1-write / 1-read synchronous RAM, single clock, registered read.
// Reset (rst, asynchronous, active-low) clears every word and rd_data.
// Same-address collisions return the old word (read-first) unless the
// macro RAM_WR_BYPASS_EN is defined, in which case the incoming write data
// is forwarded to rd_data (write-through).
module ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    ram_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;

`ifdef RAM_WR_BYPASS_EN
    logic collision;

    // Same-cycle write and read to one address selects the forwarding path.
    assign collision = bus.wr_enb && bus.rd_enb && (bus.wr_addr == bus.rd_addr);
`endif

    // Next-state of the storage array: only the addressed word changes on a write.
    always_comb begin
        mem_d = mem_q;
        if (bus.wr_enb) begin
            mem_d[bus.wr_addr] = bus.wr_data;
        end
    end

    // Next read data: hold when idle, otherwise fetch the currently stored word
    // (the pre-write contents on a collision) or forward the write data.
    always_comb begin
        rd_data_d = rd_data_q;
        if (bus.rd_enb) begin
`ifdef RAM_WR_BYPASS_EN
            if (collision) begin
                rd_data_d = bus.wr_data;
            end else begin
                rd_data_d = mem_q[bus.rd_addr];
            end
`else
            rd_data_d = mem_q[bus.rd_addr];
`endif
        end
    end

    // Storage words: cleared asynchronously, updated on every rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Read data register: cleared asynchronously so rd_data drops at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_ram.sv
// tb_ram: directed self-checking bench for ram (default and
// RAM_WR_BYPASS_EN builds). Inputs change on the falling edge; outputs are
// sampled 1 time unit after the rising edge.
module tb_ram;
    localparam int DW = 8;
    localparam int AW = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %02h expected %02h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the given port values, ending #1 after the rising edge.
    task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic re, input logic [AW-1:0] ra);
        @(negedge clk);
        bus.wr_enb  = we;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        bus.rd_enb  = re;
        bus.rd_addr = ra;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        cycle(1'b1, wa, wd, 1'b0, '0);
    endtask

    task automatic do_read(input string tag, input logic [AW-1:0] ra, input logic [DW-1:0] exp);
        cycle(1'b0, '0, '0, 1'b1, ra);
        check(tag, bus.rd_data, exp);
    endtask

    initial begin
        logic [DW-1:0] col_exp;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.wr_enb  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_enb  = 1'b0;
        bus.rd_addr = '0;

        // Test 1: reset state, then every word reads as zero.
        repeat (2) @(posedge clk);
        #1;
        check("reset_rd_data", bus.rd_data, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            do_read($sformatf("reset_word_%0d", i), i[AW-1:0], 8'h00);
        end

        // Test 2: write then read.
        do_write(4'd3, 8'hA5);
        do_read("wr_rd_3", 4'd3, 8'hA5);

        // Test 3: hold with rd_enb low while rd_addr moves.
        do_write(4'd7, 8'h77);
        do_read("hold_pre", 4'd3, 8'hA5);
        cycle(1'b0, '0, '0, 1'b0, 4'd7);
        check("hold_1", bus.rd_data, 8'hA5);
        cycle(1'b0, '0, '0, 1'b0, 4'd7);
        check("hold_2", bus.rd_data, 8'hA5);

        // Test 4: same-address collision, then a different-address pair.
        do_write(4'd5, 8'h11);
`ifdef RAM_WR_BYPASS_EN
        col_exp = 8'h22;
`else
        col_exp = 8'h11;
`endif
        cycle(1'b1, 4'd5, 8'h22, 1'b1, 4'd5);
        check("collision", bus.rd_data, col_exp);
        do_read("after_collision", 4'd5, 8'h22);
        cycle(1'b1, 4'd6, 8'h66, 1'b1, 4'd3);
        check("diff_addr_rd", bus.rd_data, 8'hA5);
        do_read("diff_addr_wr", 4'd6, 8'h66);

        // Test 5: full sweep of i ^ 0xFF, then 15 -> 0 boundary.
        for (int i = 0; i < 16; i++) begin
            do_write(i[AW-1:0], 8'hFF ^ 8'(i));
        end
        for (int i = 0; i < 16; i++) begin
            do_read($sformatf("sweep_%0d", i), i[AW-1:0], 8'hFF ^ 8'(i));
        end
        do_read("boundary_15", 4'd15, 8'hF0);
        do_read("boundary_0", 4'd0, 8'hFF);

        // Test 6: asynchronous reset between edges; writes ignored during it.
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async_clear", bus.rd_data, 8'h00);
        cycle(1'b1, 4'd9, 8'h55, 1'b1, 4'd9);
        check("in_reset_rd", bus.rd_data, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        bus.wr_enb = 1'b0;
        bus.rd_enb = 1'b0;
        do_read("post_reset_9", 4'd9, 8'h00);
        do_read("post_reset_3", 4'd3, 8'h00);
        do_write(4'd9, 8'h5A);
        do_read("post_reset_wr", 4'd9, 8'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
